// File: rtl/run_ctrl.sv
// Run/step/halt controller sitting on top of a four-phase instruction sequencer.
// Sequences start/stop strobes, tracks halt cause and counts retired instructions.
module run_ctrl (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        halt_req,
  input  logic        bp_en,
  input  logic [15:0] bp_addr,
  input  logic        cnt_clr,
  input  logic [15:0] pc,
  input  logic [3:0]  ph,
  output logic        start,
  output logic        stop,
  output logic        busy,
  output logic [1:0]  cause,
  output logic [15:0] instret
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALTING} state_t;

  state_t      r_state;
  logic        r_start;
  logic        r_pend;
  logic        r_bp;
  logic [1:0]  r_cause;
  logic [15:0] r_instret;

  logic w_ph0, w_ph3, w_idle_ph, w_bp_hit, w_stop;

  assign w_ph0     = (ph == 4'b0001);
  assign w_ph3     = (ph == 4'b1000);
  assign w_idle_ph = (ph == 4'b0000);
  assign w_bp_hit  = w_ph0 && bp_en && (pc == bp_addr);
  // Flags are registered, so a halt_req seen during PH3 only matters at the next PH3.
  assign w_stop    = w_ph3 && (((r_state == S_RUN) && (r_pend || r_bp)) ||
                               (r_state == S_STEP));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_pend  <= 1'b0;
      r_bp    <= 1'b0;
      r_cause <= 2'b00;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run_req || step_req) begin
            r_state <= run_req ? S_RUN : S_STEP;
            r_start <= 1'b1;
            r_cause <= 2'b00;
            r_pend  <= 1'b0;
            r_bp    <= 1'b0;
          end
        end
        S_RUN, S_STEP: begin
          if (halt_req) r_pend <= 1'b1;
          if ((r_state == S_RUN) && w_bp_hit) r_bp <= 1'b1;
          if (w_stop) begin
            r_state <= S_HALTING;
            if (r_state == S_STEP) r_cause <= 2'b11;
            else if (r_bp)         r_cause <= 2'b10;
            else                   r_cause <= 2'b01;
          end
        end
        S_HALTING: begin
          if (w_idle_ph) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)        r_instret <= 16'h0000;
    else if (cnt_clr) r_instret <= 16'h0000;
    else if (w_ph3)   r_instret <= r_instret + 16'h0001;
  end

  assign start   = r_start;
  assign stop    = w_stop;
  assign busy    = (r_state != S_IDLE);
  assign cause   = r_cause;
  assign instret = r_instret;

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on the rising edge.
REQ-002 SHALL have port RSTN, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port run_req, input, 1, one-cycle request for free-running execution.
REQ-004 SHALL have port step_req, input, 1, one-cycle request to execute exactly one instruction.
REQ-005 SHALL have port halt_req, input, 1, one-cycle request to halt at the next instruction boundary.
REQ-006 SHALL have port bp_en, input, 1, breakpoint enable.
REQ-007 SHALL have port bp_addr, input, 16, breakpoint instruction address.
REQ-008 SHALL have port cnt_clr, input, 1, synchronous clear of instret.
REQ-009 SHALL have port pc, input, 16, current program counter from the datapath.
REQ-010 SHALL have port ph, input, 4, phase from the phase sequencer: 0000 idle, then one-hot 0001/0010/0100/1000 (PH0..PH3).
REQ-011 SHALL have port start, output, 1, one-cycle start pulse to the phase sequencer.
REQ-012 SHALL have port stop, output, 1, stop strobe to the phase sequencer; honoured at the end of PH3.
REQ-013 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-014 SHALL have port cause, output, 2, last halt cause: 00 none, 01 halt_req, 10 breakpoint, 11 step.
REQ-015 SHALL have port instret, output, 16, count of completed instructions.

Function
REQ-016 SHALL implement states IDLE, RUN, STEP, HALTING.
REQ-017 IDLE: run_req=1 -> RUN, start=1 for the next cycle only; else step_req=1 -> STEP, start pulse likewise; run_req wins if both high.
REQ-018 Leaving IDLE via start SHALL clear cause to 00, the pending-halt flag and the breakpoint flag.
REQ-019 start SHALL be registered; exactly one cycle high per accepted request; never high outside the cycle after an IDLE->RUN/STEP transition.
REQ-020 run_req and step_req SHALL be ignored outside IDLE; halt_req SHALL be ignored in IDLE and HALTING.
REQ-021 RUN/STEP: halt_req=1 SHALL set a sticky pending-halt flag; a halt_req sampled in a PH3 cycle takes effect at the following instruction's PH3.
REQ-022 RUN: in a PH0 cycle with bp_en=1 and pc==bp_addr, SHALL set a sticky breakpoint flag (halt after that instruction completes).
REQ-023 stop SHALL be combinational from registered state/flags and ph only: stop = (ph==1000) and ((RUN and (pending or bp flag)) or STEP).
REQ-024 On the stop cycle SHALL enter HALTING and latch cause: 11 if STEP, else 10 if bp flag, else 01; breakpoint outranks pending halt.
REQ-025 HALTING: SHALL return to IDLE on the first cycle with ph==0000; stop stays low in HALTING.
REQ-026 instret SHALL increment by 1 on each cycle with ph==1000, in any state; wraps FFFF->0000.
REQ-027 cnt_clr=1 SHALL load instret with 0000, overriding a same-cycle increment.
REQ-028 busy SHALL be a decode of the state register only.

Reset
REQ-029 RSTN=0 SHALL immediately force state=IDLE, start=0, stop=0, busy=0, cause=00, instret=0000, pending and breakpoint flags cleared.
REQ-030 Reset asserted mid-RUN SHALL abandon the instruction with no stop pulse; after release the block waits in IDLE for a new request.

Verification
REQ-031 Reset, then step_req one cycle with ph walking 0000->0001->0010->0100->1000->0000 -> start one cycle, stop high in the PH3 cycle, cause=11, instret=0001, busy low once ph=0000.
REQ-032 run_req and step_req together in IDLE -> state RUN, single start pulse, no stop across three instructions, instret=0003.
REQ-033 RUN, bp_en=1, bp_addr=0x0010, pc=0x0010 at PH0 -> stop at that instruction's PH3, cause=10; halt_req in the same instruction still yields cause=10.
REQ-034 RUN, halt_req pulsed in a PH3 cycle -> no stop that PH3, stop at the next PH3, cause=01.
REQ-035 instret preset to FFFF via counting, one more PH3 -> 0000; cnt_clr high in a PH3 cycle -> 0000, not 0001.
REQ-036 RSTN low while ph=0100 in RUN -> all outputs at reset values immediately; run_req after release -> fresh start pulse, cause=00.
